// File: rtl/sdram_pll_lock_sequencer_if.sv
// sdram_pll_lock_sequencer_if: PLL lock supervisor signals; master = sequencer (locked in; pll_rst, sys_rst, ready, lock_fail, retry_cnt out), slave = PLL/downstream side
interface sdram_pll_lock_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_fail;
  logic [3:0] retry_cnt;
  modport master (input locked, output pll_rst, sys_rst, ready, lock_fail, retry_cnt);
  modport slave (output locked, input pll_rst, sys_rst, ready, lock_fail, retry_cnt);
endinterface

// File: rtl/sdram_pll_lock_sequencer.sv
// sdram_pll_lock_sequencer: pulses PLL reset, qualifies lock, holds sys_rst until stable, retries on timeout then sticks in fail; ports refclk, rst (sync high), bus (locked in; pll_rst, sys_rst, ready, lock_fail, retry_cnt out)
module sdram_pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3
) (
  input logic refclk,
  input logic rst,
  sdram_pll_lock_sequencer_if.master bus
);
  localparam int MAX_A = RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P = MAX_A > LOCK_STABLE_CYCLES ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int CW = $clog2(MAX_P + 1);
  localparam logic [CW-1:0] END_RST = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] END_TO = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] END_ST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0] MR = 4'(MAX_RETRIES);
  typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL} state_t;
  state_t state, state_n;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [3:0] retries, retries_n;
  logic locked_s;
  assign locked_s = sync[1];
  always_ff @(posedge refclk) begin
    if (rst) begin
      state <= RESET_PLL;
      cnt <= '0;
      sync <= '0;
      retries <= '0;
    end else begin
      sync <= {sync[0], bus.locked};
      state <= state_n;
      retries <= retries_n;
      cnt <= (state_n != state || state == RUN || state == FAIL) ? '0 : cnt + CW'(1);
    end
  end
  always_comb begin
    state_n = state;
    retries_n = retries;
    case (state)
      RESET_PLL: state_n = (cnt == END_RST) ? WAIT_LOCK : RESET_PLL;
      WAIT_LOCK: begin
        if (locked_s) state_n = STABLE;
        else if (cnt == END_TO) begin
          state_n = (retries == MR) ? FAIL : RESET_PLL;
          retries_n = (retries == MR) ? retries : retries + 4'd1;
        end
      end
      STABLE: state_n = !locked_s ? WAIT_LOCK : (cnt == END_ST) ? RUN : STABLE;
      RUN: state_n = locked_s ? RUN : WAIT_LOCK;
      default: state_n = state;
    endcase
  end
  assign bus.pll_rst = state == RESET_PLL;
  assign bus.sys_rst = state != RUN;
  assign bus.ready = state == RUN;
  assign bus.lock_fail = state == FAIL;
  assign bus.retry_cnt = retries;
endmodule

// File: tb/tb_sdram_pll_lock_sequencer.sv
// tb_sdram_pll_lock_sequencer: directed checks of reset, lock qualification, loss, retry exhaustion and reset override
module tb_sdram_pll_lock_sequencer;
  logic refclk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  sdram_pll_lock_sequencer_if bus();
  sdram_pll_lock_sequencer #(
    .RST_PULSE_CYCLES(4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES(2)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .bus(bus)
  );
  always #5 refclk = ~refclk;
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pll_rst"}, 4'(bus.pll_rst), 4'd1);
    chk({tag, "_sys_rst"}, 4'(bus.sys_rst), 4'd1);
    chk({tag, "_ready"}, 4'(bus.ready), 4'd0);
    chk({tag, "_lock_fail"}, 4'(bus.lock_fail), 4'd0);
    chk({tag, "_retry"}, bus.retry_cnt, 4'd0);
  endtask
  initial begin
    bus.locked = 1'b0;
    tick(2);
    chk_reset("por");
    rst = 1'b0;
    tick(3);
    chk("norm_pulse_hi", 4'(bus.pll_rst), 4'd1);
    tick(1);
    chk("norm_pulse_lo", 4'(bus.pll_rst), 4'd0);
    tick(6);
    bus.locked = 1'b1;
    tick(10);
    chk("norm_ready_early", 4'(bus.ready), 4'd0);
    chk("norm_sysrst_early", 4'(bus.sys_rst), 4'd1);
    tick(1);
    chk("norm_ready", 4'(bus.ready), 4'd1);
    chk("norm_sysrst", 4'(bus.sys_rst), 4'd0);
    chk("norm_retry", bus.retry_cnt, 4'd0);
    bus.locked = 1'b0;
    tick(2);
    chk("loss_still_run", 4'(bus.ready), 4'd1);
    tick(1);
    chk("loss_sysrst", 4'(bus.sys_rst), 4'd1);
    chk("loss_ready", 4'(bus.ready), 4'd0);
    chk("loss_no_pulse", 4'(bus.pll_rst), 4'd0);
    bus.locked = 1'b1;
    tick(10);
    chk("loss_ready_early", 4'(bus.ready), 4'd0);
    chk("loss_no_pulse2", 4'(bus.pll_rst), 4'd0);
    tick(1);
    chk("loss_ready_back", 4'(bus.ready), 4'd1);
    chk("loss_retry", bus.retry_cnt, 4'd0);
    rst = 1'b1;
    bus.locked = 1'b0;
    tick(1);
    chk_reset("rst_run");
    rst = 1'b0;
    tick(4);
    bus.locked = 1'b1;
    tick(5);
    chk("unst_burst", 4'(bus.ready), 4'd0);
    bus.locked = 1'b0;
    tick(5);
    chk("unst_gap", 4'(bus.ready), 4'd0);
    bus.locked = 1'b1;
    tick(10);
    chk("unst_ready_early", 4'(bus.ready), 4'd0);
    tick(1);
    chk("unst_ready", 4'(bus.ready), 4'd1);
    chk("unst_retry", bus.retry_cnt, 4'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("stable_not_ready", 4'(bus.ready), 4'd0);
    rst = 1'b1;
    tick(1);
    chk_reset("rst_stable");
    rst = 1'b0;
    bus.locked = 1'b0;
    tick(3);
    chk("stable_repulse", 4'(bus.pll_rst), 4'd1);
    tick(1);
    chk("exh_p1_end", 4'(bus.pll_rst), 4'd0);
    tick(19);
    chk("exh_wait1_end", 4'(bus.pll_rst), 4'd0);
    chk("exh_retry0", bus.retry_cnt, 4'd0);
    tick(1);
    chk("exh_p2", 4'(bus.pll_rst), 4'd1);
    chk("exh_retry1", bus.retry_cnt, 4'd1);
    tick(3);
    chk("exh_p2_last", 4'(bus.pll_rst), 4'd1);
    tick(1);
    chk("exh_p2_end", 4'(bus.pll_rst), 4'd0);
    tick(20);
    chk("exh_p3", 4'(bus.pll_rst), 4'd1);
    chk("exh_retry2", bus.retry_cnt, 4'd2);
    tick(4);
    chk("exh_p3_end", 4'(bus.pll_rst), 4'd0);
    tick(19);
    chk("exh_fail_early", 4'(bus.lock_fail), 4'd0);
    tick(1);
    chk("exh_fail", 4'(bus.lock_fail), 4'd1);
    chk("exh_fail_retry", bus.retry_cnt, 4'd2);
    chk("exh_fail_sysrst", 4'(bus.sys_rst), 4'd1);
    chk("exh_fail_pll", 4'(bus.pll_rst), 4'd0);
    chk("exh_fail_ready", 4'(bus.ready), 4'd0);
    bus.locked = 1'b1;
    tick(40);
    chk("fail_sticky", 4'(bus.lock_fail), 4'd1);
    chk("fail_sticky_ready", 4'(bus.ready), 4'd0);
    chk("fail_sticky_pll", 4'(bus.pll_rst), 4'd0);
    rst = 1'b1;
    bus.locked = 1'b0;
    tick(1);
    chk_reset("rst_fail");
    rst = 1'b0;
    tick(3);
    chk("fail_repulse", 4'(bus.pll_rst), 4'd1);
    tick(18);
    bus.locked = 1'b1;
    tick(3);
    chk("sim_no_pulse", 4'(bus.pll_rst), 4'd0);
    chk("sim_retry", bus.retry_cnt, 4'd0);
    tick(7);
    chk("sim_ready_early", 4'(bus.ready), 4'd0);
    tick(1);
    chk("sim_ready", 4'(bus.ready), 4'd1);
    chk("sim_retry_run", bus.retry_cnt, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
